// File: rtl/chart_sequencer.sv
// Play-mode chart stepper: presents each chart entry, runs its hit window, strobes judge.
// Optional macro CHART_SEQUENCER_PAUSE_EN adds a pause input that freezes the sequencer.
module chart_sequencer #(
  parameter int SONG_CNT_BITS = 6,
  parameter int CLOCK_BITS    = 16,
  parameter int LENGTH_BITS   = 3,
  parameter int WINDOW_BASE   = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     start,
  input  logic [SONG_CNT_BITS-1:0] track,
  input  logic [CLOCK_BITS-1:0]    system_clock,
  input  logic                     tick,
  input  logic [LENGTH_BITS-1:0]   goal_length,
  input  logic                     hit_valid,
  input  logic                     sound_over,
`ifdef CHART_SEQUENCER_PAUSE_EN
  input  logic                     pause,
`endif
  output logic [SONG_CNT_BITS-1:0] cnt,
  output logic [CLOCK_BITS-1:0]    goal_clock,
  output logic                     judge,
  output logic                     miss,
  output logic [SONG_CNT_BITS-1:0] hit_count,
  output logic [SONG_CNT_BITS-1:0] miss_count,
  output logic                     busy,
  output logic                     done
);

  localparam int WIN_W = $clog2(WINDOW_BASE + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRESENT, S_WAIT_HIT, S_WAIT_SOUND, S_JUDGE, S_DONE
  } state_t;

  state_t                   r_state;
  logic [SONG_CNT_BITS-1:0] r_cnt;
  logic [CLOCK_BITS-1:0]    r_goal_clock;
  logic [WIN_W-1:0]         r_win;
  logic                     r_judge;
  logic                     r_miss;
  logic [SONG_CNT_BITS-1:0] r_hit_count;
  logic [SONG_CNT_BITS-1:0] r_miss_count;
  logic                     r_busy;
  logic                     r_done;

  logic [WIN_W-1:0]         w_win_raw;
  logic [WIN_W-1:0]         w_win_load;
  logic                     w_last;
  logic                     w_pause;
  logic                     w_resume;

  // Long length codes shift the window to zero; never allow an empty window.
  assign w_win_raw  = WIN_W'(WINDOW_BASE) >> goal_length;
  assign w_win_load = (w_win_raw == '0) ? WIN_W'(1) : w_win_raw;
  assign w_last     = (r_cnt == (track - SONG_CNT_BITS'(1)));

`ifdef CHART_SEQUENCER_PAUSE_EN
  logic r_pause_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pause_d <= 1'b0;
    else        r_pause_d <= pause;
  end

  assign w_pause  = pause;
  assign w_resume = r_pause_d & ~pause;
`else
  assign w_pause  = 1'b0;
  assign w_resume = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_goal_clock <= '0;
      r_win        <= '0;
      r_judge      <= 1'b0;
      r_miss       <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else if (!en) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_win   <= '0;
      r_judge <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (w_pause) begin
      r_judge <= 1'b0;
    end else begin
      r_judge <= 1'b0;
      // The entry's reference time restarts when play resumes after a pause.
      if (w_resume && r_busy) r_goal_clock <= system_clock;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_cnt        <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
            if (track != '0) begin
              r_state <= S_PRESENT;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_PRESENT: begin
          r_goal_clock <= system_clock;
          r_win        <= w_win_load;
          r_state      <= S_WAIT_HIT;
        end
        S_WAIT_HIT: begin
          if (hit_valid) begin
            r_state <= S_WAIT_SOUND;
          end else if (tick) begin
            if (r_win <= WIN_W'(1)) begin
              r_win        <= '0;
              r_state      <= S_JUDGE;
              r_judge      <= 1'b1;
              r_miss       <= 1'b1;
              r_miss_count <= r_miss_count + SONG_CNT_BITS'(1);
            end else begin
              r_win <= r_win - WIN_W'(1);
            end
          end
        end
        S_WAIT_SOUND: begin
          if (sound_over) begin
            r_state     <= S_JUDGE;
            r_judge     <= 1'b1;
            r_miss      <= 1'b0;
            r_hit_count <= r_hit_count + SONG_CNT_BITS'(1);
          end
        end
        S_JUDGE: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + SONG_CNT_BITS'(1);
            r_state <= S_PRESENT;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign cnt        = r_cnt;
  assign goal_clock = r_goal_clock;
  assign judge      = r_judge;
  assign miss       = r_miss;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_chart_sequencer.sv
// Directed bench for chart_sequencer: hit path, miss timing, window clamp, empty song, en drop, reset.
module tb_chart_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        start;
  logic [5:0]  track;
  logic [15:0] system_clock = '0;
  logic        tick;
  logic [2:0]  goal_length;
  logic        hit_valid;
  logic        sound_over;
  logic [5:0]  cnt;
  logic [15:0] goal_clock;
  logic        judge;
  logic        miss;
  logic [5:0]  hit_count;
  logic [5:0]  miss_count;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int jcount = 0;
  logic [15:0] exp_gc;

  chart_sequencer #(
    .SONG_CNT_BITS(6), .CLOCK_BITS(16), .LENGTH_BITS(3), .WINDOW_BASE(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .track(track),
    .system_clock(system_clock), .tick(tick), .goal_length(goal_length),
    .hit_valid(hit_valid), .sound_over(sound_over), .cnt(cnt),
    .goal_clock(goal_clock), .judge(judge), .miss(miss),
    .hit_count(hit_count), .miss_count(miss_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (tick) system_clock <= system_clock + 16'd1;

  always @(negedge clk) if (rst_n === 1'b1 && judge === 1'b1) jcount <= jcount + 1;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; start = 1'b0; track = 6'd0; tick = 1'b1;
    goal_length = 3'd0; hit_valid = 1'b0; sound_over = 1'b0;
    cyc(2);
    check("rst_cnt", 32'(cnt), 0);
    check("rst_goal_clock", 32'(goal_clock), 0);
    check("rst_judge", 32'(judge), 0);
    check("rst_miss", 32'(miss), 0);
    check("rst_hit_count", 32'(hit_count), 0);
    check("rst_miss_count", 32'(miss_count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    cyc(1);

    // async reset while waiting for a hit
    en = 1'b1; track = 6'd3; goal_length = 3'd0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("t1_busy_present", 32'(busy), 1);
    cyc(3);
    check("t1_busy_wait", 32'(busy), 1);
    check("t1_goal_clock_set", 32'(goal_clock != 16'd0), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_busy", 32'(busy), 0);
    check("t1_async_goal_clock", 32'(goal_clock), 0);
    check("t1_async_cnt", 32'(cnt), 0);
    rst_n = 1'b1;
    cyc(10);
    check("t1_no_judge", 32'(jcount), 0);
    check("t1_idle_busy", 32'(busy), 0);

    // three hits, goal_length 0
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("t2_cnt_start", 32'(cnt), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      exp_gc = system_clock - 16'd1;
      check("t2_goal_clock", 32'(goal_clock), 32'(exp_gc));
      cyc(4);
      hit_valid = 1'b1;
      cyc(1);
      hit_valid = 1'b0;
      check("t2_no_judge_yet", 32'(judge), 0);
      cyc(1);
      sound_over = 1'b1;
      cyc(1);
      sound_over = 1'b0;
      check("t2_judge", 32'(judge), 1);
      check("t2_miss", 32'(miss), 0);
      check("t2_cnt", 32'(cnt), 32'(i));
      check("t2_hit_count", 32'(hit_count), 32'(i + 1));
      cyc(1);
      check("t2_judge_drop", 32'(judge), 0);
      if (i < 2) check("t2_cnt_next", 32'(cnt), 32'(i + 1));
      else       check("t2_done", 32'(done), 1);
    end
    check("t2_final_cnt", 32'(cnt), 2);
    check("t2_final_hits", 32'(hit_count), 3);
    check("t2_final_misses", 32'(miss_count), 0);
    check("t2_final_busy", 32'(busy), 0);
    check("t2_judges", 32'(jcount), 3);
    cyc(2);
    check("t2_done_hold", 32'(done), 1);

    // two misses, goal_length 2 -> 16-tick window
    track = 6'd2; goal_length = 3'd2; start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("t3_cnt_clear", 32'(cnt), 0);
    check("t3_hits_clear", 32'(hit_count), 0);
    check("t3_done_clear", 32'(done), 0);
    check("t3_busy", 32'(busy), 1);
    for (int n = 0; n < 2; n++) begin
      cyc(1);
      cyc(15);
      check("t3_no_early_judge", 32'(judge), 0);
      cyc(1);
      check("t3_judge", 32'(judge), 1);
      check("t3_miss", 32'(miss), 1);
      check("t3_miss_count", 32'(miss_count), 32'(n + 1));
      check("t3_cnt", 32'(cnt), 32'(n));
      cyc(1);
    end
    check("t3_done", 32'(done), 1);
    check("t3_cnt_last", 32'(cnt), 1);
    check("t3_judges", 32'(jcount), 5);

    // goal_length 7 clamps the window to one tick
    goal_length = 3'd7; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    cyc(1);
    check("t4_clamp_judge", 32'(judge), 1);
    check("t4_clamp_miss", 32'(miss), 1);
    check("t4_clamp_miss_count", 32'(miss_count), 1);
    cyc(1);
    check("t4_cnt_next", 32'(cnt), 1);
    cyc(1);
    hit_valid = 1'b1;
    cyc(1);
    hit_valid = 1'b0;
    check("t4_hit_wins_no_judge", 32'(judge), 0);
    cyc(3);
    check("t4_wait_sound_hold", 32'(judge), 0);
    check("t4_wait_sound_busy", 32'(busy), 1);
    sound_over = 1'b1;
    cyc(1);
    sound_over = 1'b0;
    check("t4_hit_judge", 32'(judge), 1);
    check("t4_hit_miss_flag", 32'(miss), 0);
    check("t4_hit_count", 32'(hit_count), 1);
    cyc(1);
    check("t4_done", 32'(done), 1);

    // empty song from IDLE
    en = 1'b0;
    cyc(1);
    check("t5_idle_done", 32'(done), 0);
    check("t5_idle_busy", 32'(busy), 0);
    en = 1'b1; track = 6'd0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("t5_done", 32'(done), 1);
    check("t5_busy", 32'(busy), 0);
    check("t5_judge", 32'(judge), 0);
    cyc(5);
    check("t5_no_judges", 32'(jcount), 7);
    check("t5_done_hold", 32'(done), 1);

    // en dropped while waiting for sound at cnt=1
    track = 6'd3; goal_length = 3'd0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    hit_valid = 1'b1;
    cyc(1);
    hit_valid = 1'b0;
    sound_over = 1'b1;
    cyc(1);
    sound_over = 1'b0;
    check("t6_first_judge", 32'(judge), 1);
    cyc(1);
    cyc(1);
    hit_valid = 1'b1;
    cyc(1);
    hit_valid = 1'b0;
    cyc(1);
    check("t6_cnt_before_drop", 32'(cnt), 1);
    check("t6_busy_before_drop", 32'(busy), 1);
    en = 1'b0;
    cyc(1);
    check("t6_cnt_cleared", 32'(cnt), 0);
    check("t6_busy_idle", 32'(busy), 0);
    check("t6_no_judge", 32'(judge), 0);
    check("t6_hits_held", 32'(hit_count), 1);
    en = 1'b1;
    cyc(3);
    check("t6_judges_idle", 32'(jcount), 8);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("t6_restart_cnt", 32'(cnt), 0);
    check("t6_restart_hits", 32'(hit_count), 0);
    check("t6_restart_busy", 32'(busy), 1);
    cyc(1);
    hit_valid = 1'b1;
    cyc(1);
    hit_valid = 1'b0;
    sound_over = 1'b1;
    cyc(1);
    sound_over = 1'b0;
    check("t6_restart_judge", 32'(judge), 1);
    check("t6_restart_judge_cnt", 32'(cnt), 0);
    check("t6_restart_hit_count", 32'(hit_count), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
